mem_scan_reader: RTL

MEM_SCAN_READER -- requirements
Module: mem_scan_reader

---
 rtl/mem_scan_pkg.sv | 16 +
 rtl/mem_scan_addr_gen.sv | 45 ++++
 rtl/mem_scan_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_scan_pkg.sv
// Shared types and defaults for the memory scan reader and its address generator.
// No logic here; FSM encoding and default geometry of the scanned data memory.
package mem_scan_pkg;

    localparam int MEM_SCAN_DEPTH  = 328;
    localparam int MEM_SCAN_ADDR_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/mem_scan_addr_gen.sv
// Word-address counter: load (reduced modulo DEPTH) or increment with wrap at DEPTH-1.
// Latency 1 cycle from load/incr to addr; no backpressure, caller gates incr.
module mem_scan_addr_gen
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W = MEM_SCAN_ADDR_W,
    parameter int DEPTH  = MEM_SCAN_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              incr,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] load_wrapped;

    // 32-bit modulo keeps DEPTH == 2**ADDR_W legal without a zero divisor.
    assign load_wrapped = ADDR_W'(32'(load_addr) % 32'(DEPTH));

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_wrapped;
        end else if (incr) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/mem_scan_reader.sv
// Streams word_count memory words from base_addr; one word per 3 cycles, read latency 1 cycle.
// Holds each word in HOLD until out_ready; optional XOR checksum port under MEM_SCAN_CHECKSUM_EN.
module mem_scan_reader
    import mem_scan_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = MEM_SCAN_ADDR_W,
    parameter int DEPTH  = MEM_SCAN_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef MEM_SCAN_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] remaining_q;
    logic [ADDR_W-1:0] remaining_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              count_zero;
    logic              last_word;
    logic              handshake;
    logic              addr_load;
    logic              addr_incr;

    assign accept     = (state_q == ST_IDLE) && start;
    assign count_zero = (word_count == '0);
    assign last_word  = (remaining_q == ADDR_W'(1));
    assign handshake  = (state_q == ST_HOLD) && out_ready;
    assign addr_load  = accept && !count_zero;
    assign addr_incr  = handshake && !last_word;

    mem_scan_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (addr_load),
        .load_addr (base_addr),
        .incr      (addr_incr),
        .addr      (addr)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    remaining_d = word_count;
                    state_d     = count_zero ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: begin
                out_data_d = mem_rdata;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (last_word) begin
                        state_d = ST_DONE;
                    end else begin
                        remaining_d = remaining_q - ADDR_W'(1);
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
        end
    end

    // Address is only meaningful alongside the strobe; park it at 0 otherwise.
    assign mem_re    = (state_q == ST_REQ);
    assign mem_addr  = mem_re ? addr : '0;
    assign out_data  = out_data_q;
    assign out_valid = (state_q == ST_HOLD);
    assign out_last  = (state_q == ST_HOLD) && last_word;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

`ifdef MEM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (accept) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q ^ out_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
